// File: rtl/simple_axi_mem_slave.sv
// Single-beat AXI4 memory responder backed by a DEPTH x 64-bit register file with byte strobes.
// Latency: write AW->W->B in 3 cycles minimum, read AR->fetch->R in 3 cycles minimum.
// Backpressure: one transaction per channel in flight; B/R outputs held stable until bready/rready.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   s_axi_aw*           write address channel (awlen must be 0, awsize 0..3)
//   s_axi_w*            write data channel (wlast ignored)
//   s_axi_b*            write response channel
//   s_axi_ar*           read address channel (arlen must be 0, arsize 0..3)
//   s_axi_r*            read data channel (rlast mirrors rvalid)
//   i_stall             (only with SIMPLE_AXI_SLAVE_STALL_EN) per-phase stall cycle count
//
// Optional build macro: SIMPLE_AXI_SLAVE_STALL_EN adds i_stall and per-FSM stall counters.
module simple_axi_mem_slave #(
  parameter int DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
  input  logic [3:0]  i_stall,
`endif
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic [7:0]  s_axi_awlen,
  input  logic [1:0]  s_axi_awburst,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awlock,
  input  logic [3:0]  s_axi_awqos,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic [7:0]  s_axi_arlen,
  input  logic [1:0]  s_axi_arburst,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arlock,
  input  logic [3:0]  s_axi_arqos,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_ADDR, R_FETCH, R_DATA} r_state_e;

  // Malformed requests (burst or oversize beat) outrank out-of-range addresses.
  function automatic logic [1:0] chk_resp(input logic [31:0] addr,
                                          input logic [7:0]  len,
                                          input logic [2:0]  size);
    if (len != 8'd0 || size[2]) begin
      return RESP_SLVERR;
    end else if (addr[31:IW+3] != '0) begin
      return RESP_DECERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  logic [63:0]   mem_q [DEPTH];

  w_state_e      w_state_q;
  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic [IW-1:0] w_idx_q;
  logic [1:0]    w_err_q;

  r_state_e      r_state_q;
  logic          arready_q;
  logic          rvalid_q;
  logic          rlast_q;
  logic [63:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [IW-1:0] r_idx_q;
  logic [1:0]    r_err_q;

  // enter_go: a newly entered state may raise its ready/valid on the entry edge.
  // w_go/r_go: a state waiting out its stall may raise its ready/valid (or fetch) now.
  logic enter_go;
  logic w_go;
  logic r_go;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
  logic [3:0] w_cnt_q;
  logic [3:0] r_cnt_q;
  logic [3:0] enter_cnt;
  assign enter_go  = (i_stall == 4'd0);
  // The entry edge itself consumes one stall cycle for handshake states.
  assign enter_cnt = i_stall - 4'd1;
  assign w_go      = (w_cnt_q == 4'd0);
  assign r_go      = (r_cnt_q == 4'd0);
`else
  assign enter_go  = 1'b1;
  assign w_go      = 1'b1;
  assign r_go      = 1'b1;
`endif

  logic w_fire_d;
  assign w_fire_d = (w_state_q == W_DATA) && wready_q && s_axi_wvalid;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      w_state_q <= W_ADDR;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      w_idx_q   <= '0;
      w_err_q   <= RESP_OKAY;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
      w_cnt_q   <= i_stall;
`endif
    end else begin
      unique case (w_state_q)
        W_ADDR: begin
          if (awready_q) begin
            if (s_axi_awvalid) begin
              awready_q <= 1'b0;
              wready_q  <= enter_go;
              w_idx_q   <= s_axi_awaddr[3 +: IW];
              w_err_q   <= chk_resp(s_axi_awaddr, s_axi_awlen, s_axi_awsize);
              w_state_q <= W_DATA;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
              w_cnt_q   <= enter_cnt;
`endif
            end
          end else if (w_go) awready_q <= 1'b1;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
          else w_cnt_q <= w_cnt_q - 4'd1;
`endif
        end
        W_DATA: begin
          if (wready_q) begin
            if (s_axi_wvalid) begin
              wready_q  <= 1'b0;
              bvalid_q  <= enter_go;
              bresp_q   <= w_err_q;
              w_state_q <= W_RESP;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
              w_cnt_q   <= enter_cnt;
`endif
            end
          end else if (w_go) wready_q <= 1'b1;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
          else w_cnt_q <= w_cnt_q - 4'd1;
`endif
        end
        W_RESP: begin
          if (bvalid_q) begin
            if (s_axi_bready) begin
              bvalid_q  <= 1'b0;
              awready_q <= enter_go;
              w_state_q <= W_ADDR;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
              w_cnt_q   <= enter_cnt;
`endif
            end
          end else if (w_go) bvalid_q <= 1'b1;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
          else w_cnt_q <= w_cnt_q - 4'd1;
`endif
        end
        default: begin
          w_state_q <= W_ADDR;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory is deliberately not reset; a write is squashed if reset is asserted on its edge.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_fire_d && (w_err_q == RESP_OKAY)) begin
      for (int k = 0; k < 8; k++) begin
        if (s_axi_wstrb[k]) begin
          mem_q[w_idx_q][8*k +: 8] <= s_axi_wdata[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM. The fetch edge samples mem_q before any write on the same edge
  // lands, so a same-cycle write to the same word returns the old contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state_q <= R_ADDR;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      r_idx_q   <= '0;
      r_err_q   <= RESP_OKAY;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
      r_cnt_q   <= i_stall;
`endif
    end else begin
      unique case (r_state_q)
        R_ADDR: begin
          if (arready_q) begin
            if (s_axi_arvalid) begin
              arready_q <= 1'b0;
              r_idx_q   <= s_axi_araddr[3 +: IW];
              r_err_q   <= chk_resp(s_axi_araddr, s_axi_arlen, s_axi_arsize);
              r_state_q <= R_FETCH;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
              // The fetch happens on the edge after entry, so no cycle is pre-consumed.
              r_cnt_q   <= i_stall;
`endif
            end
          end else if (r_go) arready_q <= 1'b1;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
          else r_cnt_q <= r_cnt_q - 4'd1;
`endif
        end
        R_FETCH: begin
          if (r_go) begin
            rdata_q   <= (r_err_q == RESP_OKAY) ? mem_q[r_idx_q] : 64'd0;
            rresp_q   <= r_err_q;
            rvalid_q  <= enter_go;
            rlast_q   <= enter_go;
            r_state_q <= R_DATA;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
            r_cnt_q   <= enter_cnt;
`endif
          end
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
          else r_cnt_q <= r_cnt_q - 4'd1;
`endif
        end
        R_DATA: begin
          if (rvalid_q) begin
            if (s_axi_rready) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= enter_go;
              r_state_q <= R_ADDR;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
              r_cnt_q   <= enter_cnt;
`endif
            end
          end else if (r_go) begin
            rvalid_q <= 1'b1;
            rlast_q  <= 1'b1;
          end
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
          else r_cnt_q <= r_cnt_q - 4'd1;
`endif
        end
        default: begin
          r_state_q <= R_ADDR;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  // Sideband fields carry no meaning for a single-beat scratch RAM.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awburst, s_axi_awcache, s_axi_awprot, s_axi_awlock,
                       s_axi_awqos, s_axi_awaddr[2:0], s_axi_wlast,
                       s_axi_arburst, s_axi_arcache, s_axi_arprot, s_axi_arlock,
                       s_axi_arqos, s_axi_araddr[2:0]};

endmodule

// File: tb/tb_simple_axi_mem_slave.sv
// Bench for simple_axi_mem_slave: scoreboard of expected B/R responses against a byte-lane memory model.
// Latency: checks AW->W->B and AR->fetch->R cycle timing explicitly in test_timing.
// Backpressure: bready/rready held low to confirm response stability.
module tb_simple_axi_mem_slave;

  localparam int DEPTH = 256;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
  logic [3:0]  i_stall = 4'd0;
`endif
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b1;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  r;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [63:0] mdl [DEPTH];

  always #5 i_clk = ~i_clk;

  simple_axi_mem_slave #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
`ifdef SIMPLE_AXI_SLAVE_STALL_EN
    .i_stall(i_stall),
`endif
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(2'b01), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awlock(1'b0), .s_axi_awqos(4'd0),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(2'b01), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arlock(1'b0), .s_axi_arqos(4'd0),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  // Expected response from the request fields alone.
  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [7:0] ln,
                                          input logic [2:0] sz);
    if (ln != 8'd0 || sz > 3'd3) return 2'b10;
    if (a >= 32'(DEPTH * 8)) return 2'b11;
    return 2'b00;
  endfunction

  // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
  task automatic do_aw(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln);
    int n = 0;
    s_axi_awaddr = a; s_axi_awsize = sz; s_axi_awlen = ln; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin @(negedge i_clk); n++; end
    total++;
    if (s_axi_awready !== 1'b1) begin
      bad++; $display("FAIL aw_wait: awready=%b required 1", s_axi_awready);
    end
    @(negedge i_clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 50) begin @(negedge i_clk); n++; end
    total++;
    if (s_axi_wready !== 1'b1) begin
      bad++; $display("FAIL w_wait: wready=%b required 1", s_axi_wready);
    end
    @(negedge i_clk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln);
    int n = 0;
    s_axi_araddr = a; s_axi_arsize = sz; s_axi_arlen = ln; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin @(negedge i_clk); n++; end
    total++;
    if (s_axi_arready !== 1'b1) begin
      bad++; $display("FAIL ar_wait: arready=%b required 1", s_axi_arready);
    end
    @(negedge i_clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic get_b(input int hold);
    int n = 0;
    logic [1:0] b0;
    logic [1:0] e;
    while (!s_axi_bvalid && n < 50) begin @(negedge i_clk); n++; end
    total++;
    if (s_axi_bvalid !== 1'b1) begin
      bad++; $display("FAIL b_wait: bvalid=%b required 1", s_axi_bvalid);
      return;
    end
    b0 = s_axi_bresp;
    repeat (hold) begin
      @(negedge i_clk);
      total++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== b0) begin
        bad++; $display("FAIL b_stable: bvalid=%b bresp=%b required 1/%b", s_axi_bvalid, s_axi_bresp, b0);
      end
    end
    s_axi_bready = 1'b1;
    @(negedge i_clk);
    s_axi_bready = 1'b0;
    total++;
    if (bq.size() == 0) begin
      bad++; $display("FAIL b_unexpected: bresp=%b with empty scoreboard", b0);
    end else begin
      e = bq.pop_front();
      if (b0 !== e) begin
        bad++; $display("FAIL bresp: got %b required %b", b0, e);
      end
    end
    total++;
    if (s_axi_bvalid !== 1'b0) begin
      bad++; $display("FAIL b_drop: bvalid=%b required 0 after handshake", s_axi_bvalid);
    end
  endtask

  task automatic get_r(input int hold);
    int n = 0;
    logic [63:0] d0;
    logic [1:0]  r0;
    logic        l0;
    rexp_t       e;
    while (!s_axi_rvalid && n < 50) begin @(negedge i_clk); n++; end
    total++;
    if (s_axi_rvalid !== 1'b1) begin
      bad++; $display("FAIL r_wait: rvalid=%b required 1", s_axi_rvalid);
      return;
    end
    d0 = s_axi_rdata; r0 = s_axi_rresp; l0 = s_axi_rlast;
    repeat (hold) begin
      @(negedge i_clk);
      total++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== d0 || s_axi_rresp !== r0 || s_axi_rlast !== l0) begin
        bad++; $display("FAIL r_stable: rvalid=%b rdata=%h rresp=%b required 1/%h/%b",
                        s_axi_rvalid, s_axi_rdata, s_axi_rresp, d0, r0);
      end
    end
    s_axi_rready = 1'b1;
    @(negedge i_clk);
    s_axi_rready = 1'b0;
    total++;
    if (rq.size() == 0) begin
      bad++; $display("FAIL r_unexpected: rdata=%h with empty scoreboard", d0);
    end else begin
      e = rq.pop_front();
      if (d0 !== e.d || r0 !== e.r) begin
        bad++; $display("FAIL rdata: got %h/%b required %h/%b", d0, r0, e.d, e.r);
      end
    end
    total++;
    if (l0 !== 1'b1) begin
      bad++; $display("FAIL rlast: got %b required 1", l0);
    end
    total++;
    if (s_axi_rvalid !== 1'b0) begin
      bad++; $display("FAIL r_drop: rvalid=%b required 0 after handshake", s_axi_rvalid);
    end
  endtask

  // Push expected bresp and apply the write to the model, then run the transaction.
  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln,
                    input logic [63:0] d, input logic [7:0] s, input int hold);
    logic [1:0] e;
    e = exp_resp(a, ln, sz);
    bq.push_back(e);
    if (e == 2'b00) begin
      for (int k = 0; k < 8; k++) if (s[k]) mdl[a[3 +: 8]][8*k +: 8] = d[8*k +: 8];
    end
    do_aw(a, sz, ln);
    do_w(d, s);
    get_b(hold);
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln, input int hold);
    logic [1:0] e;
    rexp_t x;
    e = exp_resp(a, ln, sz);
    x.r = e;
    x.d = (e == 2'b00) ? mdl[a[3 +: 8]] : 64'h0;
    rq.push_back(x);
    do_ar(a, sz, ln);
    get_r(hold);
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp, s_axi_rdata} !== '0) begin
      bad++; $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b last=%b rdata=%h required all 0",
                      s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                      s_axi_rlast, s_axi_rdata);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      bad++; $display("FAIL reset_release: awready=%b arready=%b required 1/1", s_axi_awready, s_axi_arready);
    end
  endtask

  task automatic test_byte_strobe;
    wr(32'h0, 3'd3, 8'd0, 64'h0, 8'hFF, 0);
    wr(32'h2, 3'd0, 8'd0, 64'h0000_0000_00AA_0000, 8'h04, 0);
    rd(32'h0, 3'd3, 8'd0, 0);
  endtask

  task automatic test_partial_merge;
    wr(32'h0, 3'd3, 8'd0, 64'h1122_3344_5566_7788, 8'hFF, 0);
    wr(32'h0, 3'd3, 8'd0, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0);
    rd(32'h0, 3'd3, 8'd0, 0);
  endtask

  task automatic test_hold;
    wr(32'h18, 3'd3, 8'd0, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF, 4);
    rd(32'h18, 3'd3, 8'd0, 4);
  endtask

  task automatic test_errors;
    wr(32'h8, 3'd3, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    wr(32'h8, 3'd3, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);      // SLVERR, no write
    rd(32'h8, 3'd3, 8'd0, 0);
    rd(32'(DEPTH * 8), 3'd3, 8'd0, 0);                             // DECERR
    wr(32'(DEPTH * 8), 3'd3, 8'd0, 64'h5555_5555_5555_5555, 8'hFF, 0);
    rd(32'h0, 3'd3, 8'd0, 0);                                      // no aliasing into word 0
    rd(32'h10, 3'd4, 8'd0, 0);                                     // oversize beat
    rd(32'(DEPTH * 8), 3'd3, 8'd1, 0);                             // SLVERR outranks DECERR
    wr(32'hFFFF_FFF8, 3'd3, 8'd0, 64'h1, 8'hFF, 2);
  endtask

  task automatic test_timing;
    rexp_t x;
    s_axi_wdata = 64'h7777_6666_5555_4444; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    @(negedge i_clk);
    total++;
    if (s_axi_wready !== 1'b0) begin
      bad++; $display("FAIL w_before_aw: wready=%b required 0", s_axi_wready);
    end
    bq.push_back(2'b00);
    mdl[7] = 64'h7777_6666_5555_4444;
    do_aw(32'h38, 3'd3, 8'd0);
    total++;
    if (s_axi_wready !== 1'b1) begin
      bad++; $display("FAIL wready_t1: wready=%b required 1", s_axi_wready);
    end
    @(negedge i_clk);
    s_axi_wvalid = 1'b0;
    total++;
    if (s_axi_bvalid !== 1'b1 || s_axi_wready !== 1'b0) begin
      bad++; $display("FAIL bvalid_t2: bvalid=%b wready=%b required 1/0", s_axi_bvalid, s_axi_wready);
    end
    get_b(0);
    x.d = mdl[7]; x.r = 2'b00;
    rq.push_back(x);
    s_axi_araddr = 32'h38; s_axi_arsize = 3'd3; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    @(negedge i_clk);
    s_axi_arvalid = 1'b0;
    total++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0) begin
      bad++; $display("FAIL r_fetch_t1: rvalid=%b arready=%b required 0/0", s_axi_rvalid, s_axi_arready);
    end
    @(negedge i_clk);
    total++;
    if (s_axi_rvalid !== 1'b1) begin
      bad++; $display("FAIL rvalid_t2: rvalid=%b required 1", s_axi_rvalid);
    end
    get_r(0);
  endtask

  task automatic test_collision;
    rexp_t x;
    wr(32'h28, 3'd3, 8'd0, 64'hA5A5_0000_1111_2222, 8'hFF, 0);
    total++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      bad++; $display("FAIL coll_idle: awready=%b arready=%b required 1/1", s_axi_awready, s_axi_arready);
    end
    x.d = 64'hA5A5_0000_1111_2222; x.r = 2'b00;
    rq.push_back(x);
    bq.push_back(2'b00);
    s_axi_awaddr = 32'h28; s_axi_awsize = 3'd3; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h28; s_axi_arsize = 3'd3; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    s_axi_wdata = 64'h5A5A_FFFF_EEEE_DDDD; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    @(negedge i_clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    total++;
    if (s_axi_wready !== 1'b1) begin
      bad++; $display("FAIL coll_wready: wready=%b required 1", s_axi_wready);
    end
    @(negedge i_clk);
    s_axi_wvalid = 1'b0;
    mdl[5] = 64'h5A5A_FFFF_EEEE_DDDD;
    get_b(0);
    get_r(0);
    rd(32'h28, 3'd3, 8'd0, 0);
  endtask

  task automatic test_back_to_back;
    logic [63:0] d;
    logic [7:0]  s;
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom};
      wr(32'(16 + i) << 3, 3'd3, 8'd0, d, 8'hFF, 0);
      d = {$urandom, $urandom};
      s = 8'($urandom);
      wr((32'(16 + i) << 3) | 32'(i), 3'(i % 4), 8'd0, d, s, i % 3);
    end
    for (int i = 0; i < 6; i++) rd(32'(16 + i) << 3, 3'd3, 8'd0, i % 2);
  endtask

  task automatic test_reset_mid;
    do_aw(32'h30, 3'd3, 8'd0);
    total++;
    if (s_axi_wready !== 1'b1) begin
      bad++; $display("FAIL mid_wready: wready=%b required 1 before reset", s_axi_wready);
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    total++;
    if (s_axi_wready !== 1'b0 || s_axi_awready !== 1'b0) begin
      bad++; $display("FAIL mid_reset: wready=%b awready=%b required 0/0", s_axi_wready, s_axi_awready);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    total++;
    if (s_axi_awready !== 1'b1) begin
      bad++; $display("FAIL mid_release: awready=%b required 1", s_axi_awready);
    end
    rd(32'h0, 3'd3, 8'd0, 0);
    wr(32'h30, 3'd3, 8'd0, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF, 0);
    rd(32'h30, 3'd3, 8'd0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge i_clk);
    test_reset();
    test_byte_strobe();
    test_partial_merge();
    test_hold();
    test_errors();
    test_timing();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (bq.size() != 0 || rq.size() != 0) begin
      bad++; $display("FAIL leftover: bq=%0d rq=%0d required 0/0", bq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_axi_mem_slave.md
# simple_axi_mem_slave

Single-beat AXI4 memory responder: the far end of `simple_axi_master`. It accepts one write or read transaction per channel at a time and backs it with a DEPTH×64-bit register-file memory with byte-strobe writes and OKAY/SLVERR/DECERR responses. It is used as the synthesizable target for master bring-up and as a small scratch RAM on the interconnect.

## Interface
- DEPTH, 256: number of 64-bit words; power of two, ≥2; IW = log2(DEPTH).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- s_axi_awvalid/awready  in/out  1/1  write-address handshake.
- s_axi_awaddr  in  32  byte address.
- s_axi_awsize  in  3  beat size; legal 0..3.
- s_axi_awlen  in  8  must be 0 (single beat).
- s_axi_awburst/awcache/awprot/awlock/awqos  in  2/4/3/1/4  ignored.
- s_axi_wvalid/wready  in/out  1/1  write-data handshake.
- s_axi_wdata  in  64  write data.
- s_axi_wstrb  in  8  byte lane enables.
- s_axi_wlast  in  1  ignored (single beat).
- s_axi_bvalid/bready  out/in  1/1  write response handshake.
- s_axi_bresp  out  2  write response.
- s_axi_arvalid/arready  in/out  1/1  read-address handshake.
- s_axi_araddr  in  32  byte address.
- s_axi_arsize  in  3  legal 0..3.
- s_axi_arlen  in  8  must be 0.
- s_axi_arburst/arcache/arprot/arlock/arqos  in  2/4/3/1/4  ignored.
- s_axi_rvalid/rready  out/in  1/1  read data handshake.
- s_axi_rdata  out  64  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  high whenever rvalid is high.

## Operation
- Word index = addr[3 +: IW]; addr[2:0] ignored; byte selection is by wstrb only.
- Error check at address handshake: len≠0 or size>3 → SLVERR (2'b10); addr ≥ DEPTH·8 → DECERR (2'b11); SLVERR takes priority. Errored writes do not modify memory; errored reads return rdata=0.
- Write FSM: W_ADDR (awready=1) → on AW handshake, latch index and error → W_DATA (wready=1) → on W handshake, write bytes where wstrb[k]=1 (unless error) → W_RESP (bvalid=1, bresp) → on bready → W_ADDR.
- Read FSM: R_ADDR (arready=1) → on AR handshake, latch index and error → R_FETCH (synchronous memory read) → R_DATA (rvalid=1, rlast=1, rdata, rresp) → on rready → R_ADDR.
- The two FSMs are independent and run concurrently.
- W data is never accepted before AW; wvalid asserted early simply waits.
- Outputs held stable while valid and not ready.
- Memory is not reset; contents are undefined after power-up.

## Timing
- All outputs are registered; reset values: awready=wready=bvalid=arready=rvalid=rlast=0, bresp=rresp=0, rdata=0; FSMs in W_ADDR/R_ADDR.
- awready and arready rise in the first cycle after i_rst_n deasserts.
- Write: AW handshake at cycle T → wready at T+1 → W handshake at T+1 (if wvalid) → memory updated and bvalid at T+2. Minimum write occupancy is 3 cycles plus bready wait.
- Read: AR handshake at T → R_FETCH at T+1 → rvalid at T+2. Minimum read occupancy is 3 cycles.
- Ready drops in the cycle after its handshake; there is no back-to-back AW acceptance.
- Same-word collision: a W handshake in the same cycle as R_FETCH returns the old data. A write committed in any earlier cycle is visible.
- Reset asserted mid-transaction: all FSMs return to idle on the next edge, pending responses are dropped, and partial memory writes already committed are retained.

## Configuration
- SIMPLE_AXI_SLAVE_STALL_EN: when defined, adds port i_stall (in, 4 bits). On entry to each state of either FSM, a per-FSM counter loads i_stall, and that state's ready/valid stays low until the counter reaches 0. Stall 0 gives the timing above; stall N adds N cycles per phase.
- When not defined, the port and counters are absent and the timing is exactly as above.

## Test plan
- Write addr 0x2, size 0, wstrb 0x04, wdata 0xAA<<16; then read addr 0x0 → bresp 00, rdata byte2=0xAA, rresp 00, rlast=1.
- Write 0x1122334455667788 with wstrb 0xFF at 0x0, then write wstrb 0x0F with data 0xDEADBEEF → read returns 0x11223344DEADBEEF.
- Hold bready/rready low for 4 cycles → bvalid/rvalid, bresp/rresp, rdata remain stable; completes when ready rises.
- Write awlen=1 → bresp=10, memory unchanged. Read araddr=DEPTH·8 → rresp=11, rdata=0.
- Concurrent read and write to the same word with W in R_FETCH → old data returned; a second read returns the new data.
- With SIMPLE_AXI_SLAVE_STALL_EN, i_stall=3 → awready 3 cycles late, and each later phase is also delayed 3 cycles. Reset mid-W_DATA → wready=0 next cycle and awready=1 on the cycle after release.
